// File: rtl/corefifo_pkg.sv
// Shared types and pointer-code helpers for the COREFIFO read-side logic.
package corefifo_pkg;

  // Output-buffer states; the encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // Widest pointer the helpers handle; callers zero-extend to this width and
  // truncate the result back to ADDRWIDTH+1 bits.
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros in the Gray input map to leading zeros in binary, so
  // zero-extension keeps the result exact for any ADDRWIDTH.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/corefifo_rd_ctrl_fwft_if.sv
// Read-side bundle: synchronized write pointer, consumer pop, RAM read port
// and status outputs of the FWFT read controller.
interface corefifo_rd_ctrl_fwft_if #(
  parameter int ADDRWIDTH = 3,
  parameter int WIDTH     = 8
);
  logic [ADDRWIDTH:0]   wr_ptr_gray_sync;
  logic                 re;
  logic [WIDTH-1:0]     ram_rdata;
  logic                 ram_ren;
  logic [ADDRWIDTH-1:0] ram_raddr;
  logic [WIDTH-1:0]     dout;
  logic                 dvld;
  logic                 empty;
  logic                 aempty;
  logic [ADDRWIDTH+1:0] rd_level;
  logic [ADDRWIDTH:0]   rd_ptr_gray;
  logic                 underflow;

  // The read controller.
  modport slave (
    input  wr_ptr_gray_sync, re, ram_rdata,
    output ram_ren, ram_raddr, dout, dvld, empty, aempty, rd_level,
           rd_ptr_gray, underflow
  );

  // Whatever drives the controller: the FIFO top level, or a bench.
  modport master (
    output wr_ptr_gray_sync, re, ram_rdata,
    input  ram_ren, ram_raddr, dout, dvld, empty, aempty, rd_level,
           rd_ptr_gray, underflow
  );
endinterface

// File: rtl/corefifo_rd_outbuf.sv
// Two-entry first-word-fall-through buffer: dout holds the head word, skid
// catches a word that arrives while the head is not being popped.
module corefifo_rd_outbuf
  import corefifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             srstn,
  input  logic             arr,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dvld,
  output logic [1:0]       occ
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;

  assign dvld = (state_q != S_EMPTY);
  assign pop  = re & dvld;
  assign dout = dout_q;
  assign occ  = state_q;

  // Next state and data moves for arrivals and pops.
  always_comb begin
    // NOTE: every target gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    dout_d  = dout_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (arr) begin
          dout_d  = ram_rdata;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (arr && pop) begin
          dout_d = ram_rdata;
        end else if (arr) begin
          skid_d  = ram_rdata;
          state_d = S_TWO;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          dout_d = skid_q;
          if (arr) skid_d = ram_rdata;
          else     state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and data registers; both resets clear everything.
  always_ff @(posedge clk or negedge arstn) begin
    // NOTE: dout and skid are reset too, because dout is visible at the port
    // and must read 0 out of reset, not whatever the RAM last returned.
    if (!arstn) begin
      state_q <= S_EMPTY;
      dout_q  <= '0;
      skid_q  <= '0;
    end else if (!srstn) begin
      state_q <= S_EMPTY;
      dout_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      dout_q  <= dout_d;
      skid_q  <= skid_d;
    end
  end

  // The issue rule never lets a word arrive into a full buffer without a pop.
  assert property (@(posedge clk) disable iff (!arstn || !srstn)
                   !(state_q == S_TWO && arr && !pop));

endmodule

// File: rtl/corefifo_rd_ctrl_fwft.sv
// COREFIFO read-side controller: read pointer, RAM read issue, level and
// underflow status around the FWFT output buffer. Read clock domain only.
module corefifo_rd_ctrl_fwft
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH     = 3,
  parameter int WIDTH         = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input logic                     clk,
  input logic                     arstn,
  input logic                     srstn,
  corefifo_rd_ctrl_fwft_if.slave  bus
);

  localparam int PW = ADDRWIDTH + 1;
  localparam int LW = ADDRWIDTH + 2;

  logic [PW-1:0] wr_bin, rd_ptr_bin, rd_ptr_nxt, rd_ptr_gray_q, ram_cnt;
  logic [LW-1:0] rd_level;
  logic [2:0]    committed;
  logic [1:0]    occ;
  logic          pend, underflow_q, in_rst, ram_empty, ram_ren;
  logic          buf_dvld, dvld, pop;

  // Either reset forces the status outputs to their reset values at once.
  assign in_rst = !arstn || !srstn;

  assign wr_bin     = PW'(gray2bin(PTR_MAX_W'(bus.wr_ptr_gray_sync)));
  assign ram_cnt    = wr_bin - rd_ptr_bin;
  assign ram_empty  = (ram_cnt == '0);
  assign rd_ptr_nxt = rd_ptr_bin + PW'(1);

  assign dvld = buf_dvld && !in_rst;
  assign pop  = bus.re && dvld;

  // Words already owned by the buffer after this edge: never ask for a third.
  assign committed = 3'(occ) - 3'(pop) + 3'(pend);
  assign ram_ren   = !in_rst && !ram_empty && (committed < 3'd2);

  assign rd_level = in_rst ? '0 : LW'(ram_cnt) + LW'(pend) + LW'(occ);

  assign bus.ram_ren     = ram_ren;
  assign bus.ram_raddr   = rd_ptr_bin[ADDRWIDTH-1:0];
  assign bus.dvld        = dvld;
  assign bus.empty       = !dvld;
  assign bus.rd_level    = rd_level;
  assign bus.aempty      = (rd_level <= LW'(AEMPTY_THRESH));
  assign bus.rd_ptr_gray = rd_ptr_gray_q;
  assign bus.underflow   = underflow_q;

  // Read pointer (binary and Gray), in-flight flag and underflow pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rd_ptr_bin    <= '0;
      rd_ptr_gray_q <= '0;
      pend          <= 1'b0;
      underflow_q   <= 1'b0;
    end else if (!srstn) begin
      rd_ptr_bin    <= '0;
      rd_ptr_gray_q <= '0;
      pend          <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      if (ram_ren) begin
        rd_ptr_bin    <= rd_ptr_nxt;
        rd_ptr_gray_q <= PW'(bin2gray(PTR_MAX_W'(rd_ptr_nxt)));
      end
      pend        <= ram_ren;
      underflow_q <= bus.re && !dvld;
    end
  end

  corefifo_rd_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk       (clk),
    .arstn     (arstn),
    .srstn     (srstn),
    .arr       (pend),
    .ram_rdata (bus.ram_rdata),
    .re        (bus.re),
    .dout      (bus.dout),
    .dvld      (buf_dvld),
    .occ       (occ)
  );

endmodule
